mix_column_seq: RTL and testbench

//  Sequential AES MixColumns engine for one 32-bit state column.

---
 rtl/mix_column_seq_if.sv | 25 ++
 rtl/mix_column_seq.sv | 184 ++++++++++++++++++
 tb/tb_mix_column_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mix_column_seq_if.sv
// Column request/result and multiplier handshake bundle for mix_column_seq.
// The slave modport is the engine's view; master is the surrounding datapath / multiplier side.
interface mix_column_seq_if;
   logic        start;
   logic [31:0] col_in;
   logic        inverse;
   logic        busy;
   logic        done;
   logic [31:0] col_out;
   logic        mul_valid;
   logic [7:0]  mul_data;
   logic [3:0]  mul_coef;
   logic        mul_done;
   logic [7:0]  mul_result;

   modport master (
      output start, col_in, inverse, mul_done, mul_result,
      input  busy, done, col_out, mul_valid, mul_data, mul_coef
   );

   modport slave (
      input  start, col_in, inverse, mul_done, mul_result,
      output busy, done, col_out, mul_valid, mul_data, mul_coef
   );
endinterface

// File: rtl/mix_column_seq.sv
// Sequential AES MixColumns over one column via an external serial GF(2^8) multiplier; MIX_INV_EN adds InvMixColumns.
// Latency 1+16*(D+1) cycles from start to done; stalls on mul_done only, start ignored unless idle.
module mix_column_seq (
   input  logic            clk,
   input  logic            rst_n,
   mix_column_seq_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] s_q, s_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] col_out_q, col_out_d;
   logic [3:0]  idx_q, idx_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        mul_valid_q, mul_valid_d;
   logic [7:0]  mul_data_q, mul_data_d;
   logic [3:0]  mul_coef_q, mul_coef_d;

   logic [31:0] src_col;
   logic [3:0]  nxt_idx;
   logic [1:0]  coef_k;
   logic [7:0]  issue_data;
   logic [3:0]  issue_coef;

`ifdef MIX_INV_EN
   logic        inv_q, inv_d;
   logic        inv_sel;
`else
   logic        unused_inverse;
   assign unused_inverse = bus.inverse;
`endif

   function automatic logic [7:0] byte_of(input logic [31:0] col, input logic [1:0] c);
      logic [7:0] b;
      case (c)
         2'd0:    b = col[31:24];
         2'd1:    b = col[23:16];
         2'd2:    b = col[15:8];
         default: b = col[7:0];
      endcase
      return b;
   endfunction

   function automatic logic [31:0] acc_xor(input logic [31:0] acc, input logic [1:0] r,
                                           input logic [7:0] b);
      logic [31:0] a;
      case (r)
         2'd0:    a = acc ^ {b, 24'h0};
         2'd1:    a = acc ^ {8'h0, b, 16'h0};
         2'd2:    a = acc ^ {16'h0, b, 8'h0};
         default: a = acc ^ {24'h0, b};
      endcase
      return a;
   endfunction

   function automatic logic [3:0] fwd_coef(input logic [1:0] k);
      logic [3:0] c;
      case (k)
         2'd0:    c = 4'h2;
         2'd1:    c = 4'h3;
         default: c = 4'h1;
      endcase
      return c;
   endfunction

`ifdef MIX_INV_EN
   function automatic logic [3:0] inv_coef(input logic [1:0] k);
      logic [3:0] c;
      case (k)
         2'd0:    c = 4'he;
         2'd1:    c = 4'hb;
         2'd2:    c = 4'hd;
         default: c = 4'h9;
      endcase
      return c;
   endfunction
`endif

   always_comb begin
      // Operands of the next product: product 0 comes straight from the request,
      // later ones from the latched column.
      src_col    = (state_q == IDLE) ? bus.col_in : s_q;
      nxt_idx    = (state_q == IDLE) ? 4'd0 : idx_q + 4'd1;
      coef_k     = nxt_idx[1:0] - nxt_idx[3:2];
      issue_data = byte_of(src_col, nxt_idx[1:0]);
`ifdef MIX_INV_EN
      inv_sel    = (state_q == IDLE) ? bus.inverse : inv_q;
      issue_coef = inv_sel ? inv_coef(coef_k) : fwd_coef(coef_k);
      inv_d      = inv_q;
`else
      issue_coef = fwd_coef(coef_k);
`endif

      state_d     = state_q;
      s_d         = s_q;
      acc_d       = acc_q;
      col_out_d   = col_out_q;
      idx_d       = idx_q;
      mul_valid_d = 1'b0;
      mul_data_d  = mul_data_q;
      mul_coef_d  = mul_coef_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               s_d         = bus.col_in;
               acc_d       = 32'h0;
               idx_d       = 4'd0;
`ifdef MIX_INV_EN
               inv_d       = bus.inverse;
`endif
               mul_valid_d = 1'b1;
               mul_data_d  = issue_data;
               mul_coef_d  = issue_coef;
               state_d     = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (bus.mul_done) begin
               acc_d = acc_xor(acc_q, idx_q[3:2], bus.mul_result);
               if (idx_q == 4'd15) begin
                  col_out_d = acc_d;
                  state_d   = DONE;
               end else begin
                  idx_d       = nxt_idx;
                  mul_valid_d = 1'b1;
                  mul_data_d  = issue_data;
                  mul_coef_d  = issue_coef;
                  state_d     = ISSUE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         s_q         <= 32'h0;
         acc_q       <= 32'h0;
         col_out_q   <= 32'h0;
         idx_q       <= 4'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mul_valid_q <= 1'b0;
         mul_data_q  <= 8'h0;
         mul_coef_q  <= 4'h0;
`ifdef MIX_INV_EN
         inv_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         acc_q       <= acc_d;
         col_out_q   <= col_out_d;
         idx_q       <= idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         mul_valid_q <= mul_valid_d;
         mul_data_q  <= mul_data_d;
         mul_coef_q  <= mul_coef_d;
`ifdef MIX_INV_EN
         inv_q       <= inv_d;
`endif
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.col_out   = col_out_q;
   assign bus.mul_valid = mul_valid_q;
   assign bus.mul_data  = mul_data_q;
   assign bus.mul_coef  = mul_coef_q;

endmodule

// File: tb/tb_mix_column_seq.sv
// Directed bench for mix_column_seq with a behavioural serial multiplier of programmable latency.
module tb_mix_column_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mix_column_seq_if bus ();
   mix_column_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int mul_lat  = 8;
   int n_valid  = 0;
   int last_base = 0;
   logic [3:0] coef_log[$];

   logic       model_done = 1'b0;
   logic       spur_done  = 1'b0;
   logic       idle_spur  = 1'b0;
   logic       spur_en    = 1'b0;
   logic [7:0] model_res  = 8'h0;

   assign bus.mul_done   = model_done | spur_done | idle_spur;
   assign bus.mul_result = (spur_done | idle_spur) ? 8'ha5 : model_res;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h0;
      x = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplier model: done D cycles after the valid cycle, for one cycle.
   initial begin
      logic [7:0] r;
      forever begin
         @(negedge clk);
         if (bus.mul_valid) begin
            r = gmul(bus.mul_data, bus.mul_coef);
            repeat (mul_lat) @(posedge clk);
            #1 model_done = 1'b1;
            model_res = r;
            @(posedge clk);
            #1 model_done = 1'b0;
         end
      end
   end

   // Garbage done pulse in the cycle after every real one (lands in ISSUE or DONE).
   initial begin
      forever begin
         @(negedge clk);
         if (spur_en && model_done) begin
            @(posedge clk);
            #1 spur_done = 1'b1;
            @(posedge clk);
            #1 spur_done = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (bus.mul_valid) begin
         n_valid = n_valid + 1;
         coef_log.push_back(bus.mul_coef);
      end
   end

   task automatic wait_done(input int bound, output int t, output bit ok);
      ok = 1'b0;
      t  = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (bus.done) begin
            ok = 1'b1;
            t  = cyc;
            break;
         end
      end
   endtask

   task automatic run_op(input logic [31:0] col, input logic inv, input logic [31:0] exp,
                         input int d, input string tag);
      int  t0, t;
      int  vbase;
      bit  ok;
      mul_lat   = d;
      vbase     = n_valid;
      last_base = coef_log.size();
      @(posedge clk);
      #1 bus.start = 1'b1;
      bus.col_in  = col;
      bus.inverse = inv;
      t0 = cyc;
      @(posedge clk);
      #1 bus.start = 1'b0;
      check_val({tag, "_busy"}, 32'(bus.busy), 32'd1);
      wait_done(3000, t, ok);
      check_val({tag, "_done_seen"}, 32'(ok), 32'd1);
      check_val({tag, "_latency"}, 32'(t - t0), 32'(1 + 16 * (d + 1)));
      check_val({tag, "_col_out"}, bus.col_out, exp);
      check_val({tag, "_products"}, 32'(n_valid - vbase), 32'd16);
      @(negedge clk);
      check_val({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      check_val({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
      check_val({tag, "_col_held"}, bus.col_out, exp);
   endtask

   initial begin
      int  t0, t, cnt, vbase;
      bit  ok;
      logic [31:0] inv_exp;
      bus.start   = 1'b0;
      bus.col_in  = 32'h0;
      bus.inverse = 1'b0;

      repeat (2) @(negedge clk);
      check_val("rst_busy", 32'(bus.busy), 32'd0);
      check_val("rst_done", 32'(bus.done), 32'd0);
      check_val("rst_col_out", bus.col_out, 32'h0);
      check_val("rst_mul_valid", 32'(bus.mul_valid), 32'd0);
      check_val("rst_mul_data", 32'(bus.mul_data), 32'd0);
      check_val("rst_mul_coef", 32'(bus.mul_coef), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_op(32'hdb135345, 1'b0, 32'h8e4da1bc, 8, "fwd_db");
      check_val("coef_r0c0", 32'(coef_log[last_base + 0]), 32'd2);
      check_val("coef_r0c1", 32'(coef_log[last_base + 1]), 32'd3);
      check_val("coef_r0c2", 32'(coef_log[last_base + 2]), 32'd1);
      check_val("coef_r0c3", 32'(coef_log[last_base + 3]), 32'd1);
      check_val("coef_r1c0", 32'(coef_log[last_base + 4]), 32'd1);
      check_val("coef_r1c1", 32'(coef_log[last_base + 5]), 32'd2);

      run_op(32'hf20a225c, 1'b0, 32'h9fdc589d, 1, "fwd_f2_d1");
      run_op(32'hc6c6c6c6, 1'b0, 32'hc6c6c6c6, 20, "fwd_c6_d20");

      // Stray multiplier completions while idle and during ISSUE.
      repeat (2) begin
         @(posedge clk);
         #1 idle_spur = 1'b1;
         @(posedge clk);
         #1 idle_spur = 1'b0;
      end
      @(negedge clk);
      check_val("spur_idle_busy", 32'(bus.busy), 32'd0);
      check_val("spur_idle_col", bus.col_out, 32'hc6c6c6c6);
      spur_en = 1'b1;
      run_op(32'h01010101, 1'b0, 32'h01010101, 8, "spur_01");
      spur_en = 1'b0;
      repeat (4) @(negedge clk);

      // Start held high: one run, then the next accepted right after done.
      mul_lat = 8;
      @(posedge clk);
      #1 bus.start = 1'b1;
      bus.col_in = 32'hdb135345;
      t0 = cyc;
      wait_done(3000, t, ok);
      check_val("held_done_seen", 32'(ok), 32'd1);
      check_val("held_latency", 32'(t - t0), 32'd145);
      check_val("held_col_out", bus.col_out, 32'h8e4da1bc);
      @(negedge clk);
      check_val("held_idle_busy", 32'(bus.busy), 32'd0);
      bus.col_in = 32'hf20a225c;
      t0 = cyc;
      @(posedge clk);
      #1 bus.start = 1'b0;
      check_val("held_reaccept_busy", 32'(bus.busy), 32'd1);
      wait_done(3000, t, ok);
      check_val("held2_latency", 32'(t - t0), 32'd145);
      check_val("held2_col_out", bus.col_out, 32'h9fdc589d);
      repeat (3) @(negedge clk);

      // Reset in the middle of product 7.
      vbase = n_valid;
      @(posedge clk);
      #1 bus.start = 1'b1;
      bus.col_in = 32'hdb135345;
      @(posedge clk);
      #1 bus.start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (n_valid - vbase >= 7) begin
            ok = 1'b1;
            break;
         end
      end
      check_val("rst_mid_reached", 32'(ok), 32'd1);
      rst_n = 1'b0;
      #1;
      check_val("rst_mid_busy", 32'(bus.busy), 32'd0);
      check_val("rst_mid_done", 32'(bus.done), 32'd0);
      check_val("rst_mid_col_out", bus.col_out, 32'h0);
      check_val("rst_mid_mul_valid", 32'(bus.mul_valid), 32'd0);
      check_val("rst_mid_mul_data", 32'(bus.mul_data), 32'd0);
      check_val("rst_mid_mul_coef", 32'(bus.mul_coef), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) cnt++;
      end
      check_val("rst_mid_no_done", 32'(cnt), 32'd0);
      run_op(32'hdb135345, 1'b0, 32'h8e4da1bc, 8, "post_rst");

`ifdef MIX_INV_EN
      inv_exp = 32'hdb135345;
`else
      inv_exp = 32'hcd504506;
`endif
      run_op(32'h8e4da1bc, 1'b1, inv_exp, 8, "inverse");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
